rgb888_2_raw8: RTL
==================

# rgb888_2_raw8

Re-mosaicing block: converts an RGB888 video stream into an 8-bit Bayer RAW stream by keeping, per pixel, only the colour component its Bayer site samples. It sits in front of the ISP demosaic path as a RAW stimulus source, fed by the test-pattern generator or by a decoded RGB frame. It also provides a closed loop for checking the demosaic end to end. It tracks line and frame geometry and flags malformed lines and frames.

## Interface
- H_SIZE, 640, active pixels per line (14 bit)
- V_SIZE, 480, active lines per frame (11 bit)
- I_clk  in  1  pixel clock
- I_rst_n  in  1  reset, asynchronous, active-low; clock I_clk
- I_rgb_vs  in  1  frame valid, high for the whole frame
- I_rgb_de  in  1  pixel valid, high for each active pixel
- I_rgb_r / I_rgb_g / I_rgb_b  in  8 each  pixel colour components
- I_pattern  in  2  Bayer order: 0 GRBG, 1 RGGB, 2 BGGR, 3 GBRG
- O_raw_vs  out  1  I_rgb_vs delayed 2 cycles
- O_raw_de  out  1  I_rgb_de delayed 2 cycles
- O_raw_data  out  8  mosaiced pixel
- O_line_err  out  1  one-cycle pulse when a line length is not H_SIZE
- O_frame_err  out  1  one-cycle pulse when a frame line count is not V_SIZE

## Operation
- **Pattern latch.** pattern_q takes I_pattern on the rising edge of I_rgb_vs (vs & ~vs_d1). It holds for the whole frame, so changing I_pattern mid-frame has no effect until the next frame.
- **Horizontal counter.** h_cnt is 14 bits and counts pixels of the current line.
  - Cleared whenever I_rgb_de = 0.
  - Increments on each I_rgb_de = 1 cycle; the first pixel of a line has index 0.
  - Saturates at 16383.
- **Vertical counter.** v_cnt is 11 bits.
  - Cleared whenever I_rgb_vs = 0.
  - Increments on each de falling edge (~de & de_d1) while vs = 1.
  - Saturates at 2047.
- **Site phase.** row = v_cnt[0] ^ pattern_q[1], col = h_cnt[0] ^ pattern_q[0]. These select the base GRBG component:
  - row 0, col 0: G
  - row 0, col 1: R
  - row 1, col 0: B
  - row 1, col 1: G
- **Pipeline stage 1.**
  - Register r, g, b, de, vs.
  - Register the 2-bit site code, computed from the counters' pre-increment values for the current pixel.
- **Pipeline stage 2.**
  - O_raw_data = selected component when de_s1 = 1, else 8'd0.
  - O_raw_de = de_s1 and O_raw_vs = vs_s1, both registered.
- **Line check.** len_q captures the completed line's length.
  - On a de falling edge, if len_q ≠ H_SIZE, O_line_err pulses high for one cycle.
  - The check applies to every line, including lines beyond V_SIZE.
- **Frame check.** On a vs falling edge, if v_cnt ≠ V_SIZE, O_frame_err pulses high for one cycle.
- **Out-of-frame input.** A de pulse while vs = 0 is still mosaiced and passed through with v_cnt = 0. The line check applies to it, and v_cnt does not advance.
- **Reset values.** All outputs are 0 in reset, as are counters, pattern_q and pipeline registers. Reset mid-frame drops the partial frame. After release, no error is flagged until the next complete edge pair of de or vs.

## Timing
- Data latency: a pixel presented at cycle t appears on O_raw_data at t+2 with O_raw_de = 1. vs and de have the same 2-cycle delay, so outputs stay mutually aligned.
- O_line_err: input de falls at cycle t (de = 0, de_d1 = 1) → O_line_err = 1 at t+1 only. This coincides with the last output pixel, since O_raw_de falls at t+2.
- O_frame_err: input vs falls at cycle t → O_frame_err = 1 at t+1 only.
- Simultaneous de fall and vs fall:
  - The v_cnt increment for that last line is included in the frame check, so a full frame gives no error.
  - Both error pulses may assert in the same cycle.
- Back-to-back lines with one idle cycle are supported: h_cnt is cleared in the idle cycle.
- The block has no backpressure: one pixel is accepted every cycle that de = 1.

## Structure
- Shared package isp_pkg:
  - Bayer order constants BAYER_GRBG = 0, BAYER_RGGB = 1, BAYER_BGGR = 2, BAYER_GBRG = 3.
  - Site code constants SITE_R, SITE_G, SITE_B.
  - The demosaic block uses the same constants.
- One sub-module, bayer_phase_cnt. It contains:
  - the h_cnt and v_cnt counters, the edge detectors and pattern_q;
  - the line and frame length checks.
  - It outputs the site code, O_line_err and O_frame_err.
- The top level holds the data pipeline and the component mux.

## Test plan
- 4×2 frame (H_SIZE = 4, V_SIZE = 2), pattern 0, pixel (r, g, b) = (0x10+i, 0x20+i, 0x30+i), where i is the pixel's position within its line (0-3).
  - Line 0 output is 0x20, 0x11, 0x22, 0x13; line 1 output is 0x30, 0x21, 0x32, 0x23.
  - No error pulses.
- Same frame repeated for patterns 1, 2 and 3 → the line-0 first pixel is R (0x10), B (0x30) and G (0x20) respectively. Changing I_pattern mid-frame has no effect until the next vs rise.
- One line of 3 pixels with H_SIZE = 4 → O_line_err pulses exactly one cycle, one cycle after input de falls. The next correct line produces no pulse.
- Frame of 3 lines with V_SIZE = 2 → O_frame_err pulses once, one cycle after vs falls. A frame whose last de fall coincides with the vs fall gives no error.
- Latency and alignment with random de gaps → O_raw_de and O_raw_vs equal the inputs delayed by 2 cycles. O_raw_data is 0 whenever O_raw_de = 0.
- Assert I_rst_n low mid-line → all outputs are 0 immediately. After release, the next full frame is mosaiced correctly with no spurious error pulses.

Source files
------------

// File: rtl/isp_pkg.sv
// rtl/isp_pkg.sv - Bayer order and colour-site constants shared by the ISP mosaic/demosaic blocks
package isp_pkg;

  localparam logic [1:0] BAYER_GRBG = 2'd0;
  localparam logic [1:0] BAYER_RGGB = 2'd1;
  localparam logic [1:0] BAYER_BGGR = 2'd2;
  localparam logic [1:0] BAYER_GBRG = 2'd3;

  localparam int unsigned H_CNT_W = 14;
  localparam int unsigned V_CNT_W = 11;

  typedef enum logic [1:0] {
    SITE_G = 2'd0,
    SITE_R = 2'd1,
    SITE_B = 2'd2
  } site_e;

  // Base GRBG tile; other orders are reached by flipping row/col phase.
  function automatic site_e bayer_site(input logic row, input logic col);
    case ({row, col})
      2'b01:   return SITE_R;
      2'b10:   return SITE_B;
      default: return SITE_G;
    endcase
  endfunction

endpackage

// File: rtl/bayer_phase_cnt.sv
// rtl/bayer_phase_cnt.sv - line/frame position counters, Bayer site phase and geometry checks
module bayer_phase_cnt
  import isp_pkg::*;
#(
  parameter int unsigned H_SIZE = 640,
  parameter int unsigned V_SIZE = 480
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_vs,
  input  logic       I_de,
  input  logic [1:0] I_pattern,
  output site_e      O_site,
  output logic       O_line_err,
  output logic       O_frame_err
);

  localparam logic [H_CNT_W-1:0] H_LEN = H_CNT_W'(H_SIZE);
  localparam logic [V_CNT_W-1:0] V_LEN = V_CNT_W'(V_SIZE);

  logic               r_vs_d1;
  logic               r_de_d1;
  logic               r_vs_arm;
  logic               r_de_arm;
  logic [1:0]         r_pattern_q;
  logic [H_CNT_W-1:0] r_h_cnt;
  logic [V_CNT_W-1:0] r_v_cnt;

  logic               w_vs_rise;
  logic               w_vs_fall;
  logic               w_de_fall;
  logic [1:0]         w_pat;
  logic [V_CNT_W-1:0] w_v_row;
  logic [V_CNT_W-1:0] w_v_final;

  assign w_vs_rise = I_vs & ~r_vs_d1;
  assign w_vs_fall = ~I_vs & r_vs_d1;
  assign w_de_fall = ~I_de & r_de_d1;

  // A pixel arriving on the vs-rise cycle already belongs to the new frame's order.
  assign w_pat   = w_vs_rise ? I_pattern : r_pattern_q;
  assign w_v_row = I_vs ? r_v_cnt : '0;

  // Last line's de fall coinciding with vs fall still counts toward the frame.
  assign w_v_final = (w_de_fall && (r_v_cnt != '1)) ? r_v_cnt + V_CNT_W'(1) : r_v_cnt;

  assign O_site = bayer_site(w_v_row[0] ^ w_pat[1], r_h_cnt[0] ^ w_pat[0]);

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_vs_d1     <= 1'b0;
      r_de_d1     <= 1'b0;
      r_vs_arm    <= 1'b0;
      r_de_arm    <= 1'b0;
      r_pattern_q <= BAYER_GRBG;
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      O_line_err  <= 1'b0;
      O_frame_err <= 1'b0;
    end else begin
      r_vs_d1 <= I_vs;
      r_de_d1 <= I_de;
      // Arms only after a low level is seen, so a frame cut by reset is never checked.
      if (!I_vs) r_vs_arm <= 1'b1;
      if (!I_de) r_de_arm <= 1'b1;

      if (w_vs_rise) r_pattern_q <= I_pattern;

      if (!I_de)
        r_h_cnt <= '0;
      else if (r_h_cnt != '1)
        r_h_cnt <= r_h_cnt + H_CNT_W'(1);

      if (!I_vs)
        r_v_cnt <= '0;
      else if (w_de_fall && (r_v_cnt != '1))
        r_v_cnt <= r_v_cnt + V_CNT_W'(1);

      O_line_err  <= w_de_fall & r_de_arm & (r_h_cnt != H_LEN);
      O_frame_err <= w_vs_fall & r_vs_arm & (w_v_final != V_LEN);
    end
  end

endmodule

// File: rtl/rgb888_2_raw8.sv
// rtl/rgb888_2_raw8.sv - RGB888 to 8-bit Bayer RAW re-mosaicing with line/frame checks
module rgb888_2_raw8
  import isp_pkg::*;
#(
  parameter int unsigned H_SIZE = 640,
  parameter int unsigned V_SIZE = 480
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_rgb_vs,
  input  logic       I_rgb_de,
  input  logic [7:0] I_rgb_r,
  input  logic [7:0] I_rgb_g,
  input  logic [7:0] I_rgb_b,
  input  logic [1:0] I_pattern,
  output logic       O_raw_vs,
  output logic       O_raw_de,
  output logic [7:0] O_raw_data,
  output logic       O_line_err,
  output logic       O_frame_err
);

  site_e      w_site;
  logic [7:0] w_pix;

  logic [7:0] r_r_s1;
  logic [7:0] r_g_s1;
  logic [7:0] r_b_s1;
  logic       r_de_s1;
  logic       r_vs_s1;
  site_e      r_site_s1;

  bayer_phase_cnt #(
    .H_SIZE (H_SIZE),
    .V_SIZE (V_SIZE)
  ) u_phase (
    .I_clk       (I_clk),
    .I_rst_n     (I_rst_n),
    .I_vs        (I_rgb_vs),
    .I_de        (I_rgb_de),
    .I_pattern   (I_pattern),
    .O_site      (w_site),
    .O_line_err  (O_line_err),
    .O_frame_err (O_frame_err)
  );

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_r_s1    <= '0;
      r_g_s1    <= '0;
      r_b_s1    <= '0;
      r_de_s1   <= 1'b0;
      r_vs_s1   <= 1'b0;
      r_site_s1 <= SITE_G;
    end else begin
      r_r_s1    <= I_rgb_r;
      r_g_s1    <= I_rgb_g;
      r_b_s1    <= I_rgb_b;
      r_de_s1   <= I_rgb_de;
      r_vs_s1   <= I_rgb_vs;
      r_site_s1 <= w_site;
    end
  end

  always_comb begin
    w_pix = r_g_s1;
    case (r_site_s1)
      SITE_R:  w_pix = r_r_s1;
      SITE_B:  w_pix = r_b_s1;
      default: w_pix = r_g_s1;
    endcase
  end

  // Blanking is forced to zero so downstream never sees stale colour data.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_raw_vs   <= 1'b0;
      O_raw_de   <= 1'b0;
      O_raw_data <= '0;
    end else begin
      O_raw_vs   <= r_vs_s1;
      O_raw_de   <= r_de_s1;
      O_raw_data <= r_de_s1 ? w_pix : 8'd0;
    end
  end

endmodule
